// File: rtl/rs_multi_cdb_pkg.sv
// Shared defaults and ordertype codes for the multi-CDB reservation station.
// Optional build macro RS_AGE_ORDER_EN is consumed by rs_multi_cdb and rs_multi_cdb_pick.
package rs_multi_cdb_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NCDB   = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 4;
    localparam int DEF_OP_W   = 6;

    typedef enum logic [DEF_OP_W-1:0] {
        OT_LUI   = 6'd1,
        OT_AUIPC = 6'd2,
        OT_JAL   = 6'd3,
        OT_JALR  = 6'd4,
        OT_BEQ   = 6'd5,
        OT_BNE   = 6'd6,
        OT_BLT   = 6'd7,
        OT_BGE   = 6'd8,
        OT_ADD   = 6'd19,
        OT_SUB   = 6'd20,
        OT_AND   = 6'd21,
        OT_OR    = 6'd22,
        OT_XOR   = 6'd23
    } ordertype_e;

endpackage

// File: rtl/rs_multi_cdb_pick.sv
// Ready-vector to single grant index. With RS_AGE_ORDER_EN an age matrix picks the oldest
// ready entry; otherwise the lowest-index ready entry wins and no state is kept.
module rs_multi_cdb_pick
    import rs_multi_cdb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
`ifdef RS_AGE_ORDER_EN
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0]         alloc,
    input  logic [DEPTH-1:0]         free_oh,
`endif
    input  logic [DEPTH-1:0]         req,
    output logic [$clog2(DEPTH)-1:0] grant_idx,
    output logic                     any_req
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] cand;

`ifdef RS_AGE_ORDER_EN
    // age_q[r][c] = 1 means entry c was already resident when entry r was allocated
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        age_d = age_q;
        if (rdy) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int c = 0; c < DEPTH; c++) begin
                    if (flush) begin
                        age_d[r][c] = 1'b0;
                    end else begin
                        if (alloc[r])   age_d[r][c] = valid[c];
                        if (free_oh[c]) age_d[r][c] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) age_q[r] <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++) cand[i] = req[i] && ((age_q[i] & req) == '0);
    end
`else
    assign cand = req;
`endif

    always_comb begin
        grant_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (cand[i]) grant_idx = IDX_W'(i);
        end
        any_req = |cand;
    end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station: DEPTH entries, NCDB-channel wakeup, one registered issue per cycle.
// Build macro RS_AGE_ORDER_EN selects oldest-first issue instead of lowest-index.
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NCDB   = DEF_NCDB,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [OP_W-1:0]          disp_op,
    input  logic [DATA_W-1:0]        disp_vj,
    input  logic [DATA_W-1:0]        disp_vk,
    input  logic                     disp_qj_v,
    input  logic                     disp_qk_v,
    input  logic [TAG_W-1:0]         disp_qj,
    input  logic [TAG_W-1:0]         disp_qk,
    input  logic [DATA_W-1:0]        disp_a,
    input  logic [DATA_W-1:0]        disp_pc,
    input  logic [TAG_W-1:0]         disp_tag,
    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*TAG_W-1:0]    cdb_tag,
    input  logic [NCDB*DATA_W-1:0]   cdb_value,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [OP_W-1:0]          iss_op,
    output logic [DATA_W-1:0]        iss_vj,
    output logic [DATA_W-1:0]        iss_vk,
    output logic [DATA_W-1:0]        iss_a,
    output logic [DATA_W-1:0]        iss_pc,
    output logic [TAG_W-1:0]         iss_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  tag;
    } ent_t;

    logic [DEPTH-1:0] valid_q, valid_d, qj_v_q, qj_v_d, qk_v_q, qk_v_d;
    logic [TAG_W-1:0] qj_q [DEPTH];
    logic [TAG_W-1:0] qj_d [DEPTH];
    logic [TAG_W-1:0] qk_q [DEPTH];
    logic [TAG_W-1:0] qk_d [DEPTH];
    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    ent_t             iss_q, iss_d;
    logic             iss_valid_q, iss_valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] grant_idx, free_idx;
    logic             any_ready, full, out_load, disp_fire, issue_fire;
    logic [DATA_W:0]  byp_j, byp_k, wk_j, wk_k;

    // Returns {hit, value}; the lowest-numbered matching channel wins.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0]       t,
                                                   input logic [NCDB-1:0]        v,
                                                   input logic [NCDB*TAG_W-1:0]  tags,
                                                   input logic [NCDB*DATA_W-1:0] vals);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NCDB-1; k >= 0; k--) begin
            if (v[k] && tags[k*TAG_W +: TAG_W] == t) r = {1'b1, vals[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    assign full       = (count_q == CNT_W'(DEPTH));
    assign disp_ready = rdy && !full;
    assign ready_vec  = valid_q & ~qj_v_q & ~qk_v_q;
    assign out_load   = !iss_valid_q || iss_ready;
    assign disp_fire  = rdy && !flush && disp_valid && !full;
    assign issue_fire = rdy && !flush && out_load && any_ready;
    assign byp_j      = cdb_lookup(disp_qj, cdb_valid, cdb_tag, cdb_value);
    assign byp_k      = cdb_lookup(disp_qk, cdb_valid, cdb_tag, cdb_value);

    // Free slot comes from pre-edge valid bits, so an entry issued this cycle is not reused.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

`ifdef RS_AGE_ORDER_EN
    logic [DEPTH-1:0] alloc_oh, free_oh;

    always_comb begin
        alloc_oh = '0;
        free_oh  = '0;
        if (disp_fire)  alloc_oh[free_idx] = 1'b1;
        if (issue_fire) free_oh[grant_idx] = 1'b1;
    end

    rs_multi_cdb_pick #(.DEPTH(DEPTH)) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flush     (flush),
        .valid     (valid_q),
        .alloc     (alloc_oh),
        .free_oh   (free_oh),
        .req       (ready_vec),
        .grant_idx (grant_idx),
        .any_req   (any_ready)
    );
`else
    rs_multi_cdb_pick #(.DEPTH(DEPTH)) u_pick (
        .req       (ready_vec),
        .grant_idx (grant_idx),
        .any_req   (any_ready)
    );
`endif

    always_comb begin
        valid_d     = valid_q;
        qj_v_d      = qj_v_q;
        qk_v_d      = qk_v_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        ent_d       = ent_q;
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        count_d     = count_q;
        wk_j        = '0;
        wk_k        = '0;
        if (rdy) begin
            if (flush) begin
                valid_d     = '0;
                qj_v_d      = '0;
                qk_v_d      = '0;
                iss_valid_d = 1'b0;
                count_d     = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    wk_j = cdb_lookup(qj_q[i], cdb_valid, cdb_tag, cdb_value);
                    wk_k = cdb_lookup(qk_q[i], cdb_valid, cdb_tag, cdb_value);
                    if (valid_q[i] && qj_v_q[i] && wk_j[DATA_W]) begin
                        qj_v_d[i]   = 1'b0;
                        ent_d[i].vj = wk_j[DATA_W-1:0];
                    end
                    if (valid_q[i] && qk_v_q[i] && wk_k[DATA_W]) begin
                        qk_v_d[i]   = 1'b0;
                        ent_d[i].vk = wk_k[DATA_W-1:0];
                    end
                end
                // Selection looks only at pre-edge ready bits: no wakeup-to-select bypass.
                if (out_load) begin
                    iss_valid_d = any_ready;
                    if (any_ready) begin
                        iss_d              = ent_q[grant_idx];
                        valid_d[grant_idx] = 1'b0;
                    end
                end
                if (disp_fire) begin
                    valid_d[free_idx] = 1'b1;
                    qj_v_d[free_idx]  = disp_qj_v && !byp_j[DATA_W];
                    qk_v_d[free_idx]  = disp_qk_v && !byp_k[DATA_W];
                    qj_d[free_idx]    = disp_qj;
                    qk_d[free_idx]    = disp_qk;
                    ent_d[free_idx].op  = disp_op;
                    ent_d[free_idx].vj  = (disp_qj_v && byp_j[DATA_W]) ? byp_j[DATA_W-1:0] : disp_vj;
                    ent_d[free_idx].vk  = (disp_qk_v && byp_k[DATA_W]) ? byp_k[DATA_W-1:0] : disp_vk;
                    ent_d[free_idx].a   = disp_a;
                    ent_d[free_idx].pc  = disp_pc;
                    ent_d[free_idx].tag = disp_tag;
                end
                count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            qj_v_q      <= '0;
            qk_v_q      <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            qj_v_q      <= qj_v_d;
            qk_v_q      <= qk_v_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            count_q     <= count_d;
        end
    end

    // Entry payload carries no reset; the valid/pending bits above qualify it.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
        qj_q  <= qj_d;
        qk_q  <= qk_d;
    end

    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_q.op;
    assign iss_vj    = iss_q.vj;
    assign iss_vk    = iss_q.vk;
    assign iss_a     = iss_q.a;
    assign iss_pc    = iss_q.pc;
    assign iss_tag   = iss_q.tag;
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed bench for rs_multi_cdb (DEPTH=16, NCDB=2); order expectations follow RS_AGE_ORDER_EN.
module tb_rs_multi_cdb;
    localparam int DEPTH  = 16;
    localparam int NCDB   = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   rdy = 1'b1;
    logic                   flush = 1'b0;
    logic                   disp_valid = 1'b0;
    logic                   disp_ready;
    logic [OP_W-1:0]        disp_op = '0;
    logic [DATA_W-1:0]      disp_vj = '0, disp_vk = '0, disp_a = '0, disp_pc = '0;
    logic                   disp_qj_v = 1'b0, disp_qk_v = 1'b0;
    logic [TAG_W-1:0]       disp_qj = '0, disp_qk = '0, disp_tag = '0;
    logic [NCDB-1:0]        cdb_valid = '0;
    logic [NCDB*TAG_W-1:0]  cdb_tag = '0;
    logic [NCDB*DATA_W-1:0] cdb_value = '0;
    logic                   iss_valid;
    logic                   iss_ready = 1'b0;
    logic [OP_W-1:0]        iss_op;
    logic [DATA_W-1:0]      iss_vj, iss_vk, iss_a, iss_pc;
    logic [TAG_W-1:0]       iss_tag;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;

    int n_checks = 0;
    int n_errors = 0;

    rs_multi_cdb #(.DEPTH(DEPTH), .NCDB(NCDB), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj_v(disp_qj_v), .disp_qk_v(disp_qk_v),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_a(disp_a), .disp_pc(disp_pc), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_vj(iss_vj),
        .iss_vk(iss_vk), .iss_a(iss_a), .iss_pc(iss_pc), .iss_tag(iss_tag),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjv, input logic [3:0] qj, input logic qkv, input logic [3:0] qk,
                            input logic [3:0] tag);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_vj    = vj;
        disp_vk    = vk;
        disp_qj_v  = qjv;
        disp_qj    = qj;
        disp_qk_v  = qkv;
        disp_qk    = qk;
        disp_a     = 32'hA000_0000 | vj;
        disp_pc    = 32'h0000_1000 + vj;
        disp_tag   = tag;
    endtask

    task automatic disp_one(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjv, input logic [3:0] qj, input logic qkv, input logic [3:0] qk,
                            input logic [3:0] tag);
        set_disp(op, vj, vk, qjv, qj, qkv, qk, tag);
        step();
        disp_valid = 1'b0;
    endtask

    task automatic bcast(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                         input logic [3:0] t1, input logic [31:0] d1);
        cdb_valid = v;
        cdb_tag   = {t1, t0};
        cdb_value = {d1, d0};
        step();
        cdb_valid = '0;
    endtask

    logic [3:0]  wait_tags [6];
    logic [31:0] exp_first_vj;
    logic [3:0]  exp_first_tag, exp_second_tag;

    initial begin
        // Reset state
        step();
        step();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_disp_ready", disp_ready, 1);
        rst_n = 1'b1;
        step();

        // Asynchronous reset with five resident entries and one op in the output register
        iss_ready = 1'b0;
        for (int k = 0; k < 6; k++) disp_one(6'd19, 32'(k), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'(k));
        check("fill_count", count, 5);
        check("fill_iss_valid", iss_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_iss_valid", iss_valid, 0);
        #1 rst_n = 1'b1;
        step();

        // Same-cycle CDB bypass at dispatch; channel 1 carries the same tag but is not valid
        iss_ready = 1'b1;
        set_disp(6'h13, 32'hDEAD, 32'h55, 1'b1, 4'd3, 1'b0, 4'd0, 4'h6);
        cdb_valid = 2'b01;
        cdb_tag   = {4'd3, 4'd3};
        cdb_value = {32'hBAD0, 32'h1234};
        step();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        check("byp_lat1_iss_valid", iss_valid, 0);
        check("byp_lat1_count", count, 1);
        step();
        check("byp_iss_valid", iss_valid, 1);
        check("byp_vj", iss_vj, 32'h1234);
        check("byp_vk", iss_vk, 32'h55);
        check("byp_op", iss_op, 6'h13);
        check("byp_tag", iss_tag, 4'h6);
        check("byp_a", iss_a, 32'hA000_DEAD);
        check("byp_pc", iss_pc, 32'h0000_1000 + 32'hDEAD);
        check("byp_count", count, 0);
        step();
        check("byp_drained", iss_valid, 0);

        // Two channels wake two different entries in the same cycle
        disp_one(6'd1, 32'd0, 32'h22, 1'b1, 4'd5, 1'b0, 4'd0, 4'd7);
        disp_one(6'd2, 32'h33, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd8);
        check("dual_count", count, 2);
        check("dual_wait_iss", iss_valid, 0);
        bcast(2'b11, 4'd5, 32'hAAAA, 4'd9, 32'hBBBB);
        check("dual_no_bypass", iss_valid, 0);
        step();
        check("dual_first_valid", iss_valid, 1);
        check("dual_first_tag", iss_tag, 4'd7);
        check("dual_first_vj", iss_vj, 32'hAAAA);
        step();
        check("dual_second_valid", iss_valid, 1);
        check("dual_second_tag", iss_tag, 4'd8);
        check("dual_second_vk", iss_vk, 32'hBBBB);
        check("dual_second_vj", iss_vj, 32'h33);
        step();
        check("dual_done_iss", iss_valid, 0);
        check("dual_done_empty", empty, 1);

        // Fill to DEPTH under backpressure
        iss_ready = 1'b0;
        for (int k = 0; k < 16; k++) disp_one(6'd19, 32'(k), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'(k));
        check("bp16_count", count, 15);
        check("bp16_iss_valid", iss_valid, 1);
        check("bp16_disp_ready", disp_ready, 1);
        disp_one(6'd19, 32'd16, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        check("full_count", count, 16);
        check("full_disp_ready", disp_ready, 0);
        set_disp(6'd19, 32'd99, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            check("stall_vj", iss_vj, 32'd0);
        end
        check("stall_count", count, 16);
        iss_ready = 1'b1;
        step();
        disp_valid = 1'b0;
`ifdef RS_AGE_ORDER_EN
        exp_first_vj = 32'd1;
`else
        exp_first_vj = 32'd2;
`endif
        check("full_no_reuse_count", count, 15);
        check("full_next_vj", iss_vj, exp_first_vj);
        for (int c = 0; c < 17; c++) step();
        check("drain_empty", empty, 1);
        check("drain_iss_valid", iss_valid, 0);

        // Ordering: P lands in idx 4, Q later in idx 1, both wait on tag 7
        wait_tags[0] = 4'd10; wait_tags[1] = 4'd12; wait_tags[2] = 4'd10;
        wait_tags[3] = 4'd10; wait_tags[4] = 4'd11; wait_tags[5] = 4'd10;
        for (int k = 0; k < 6; k++) disp_one(6'd20, 32'd0, 32'd0, 1'b1, wait_tags[k], 1'b0, 4'd0, 4'd0);
        bcast(2'b01, 4'd11, 32'h0, 4'd0, 32'h0);
        step();
        step();
        check("ord_after_free4", count, 5);
        disp_one(6'd21, 32'h44, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'hA);
        bcast(2'b01, 4'd12, 32'h0, 4'd0, 32'h0);
        step();
        step();
        check("ord_after_free1", count, 5);
        disp_one(6'd22, 32'h11, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'hB);
        check("ord_count", count, 6);
        bcast(2'b11, 4'd7, 32'h77, 4'd7, 32'h99);
        check("ord_no_bypass", iss_valid, 0);
`ifdef RS_AGE_ORDER_EN
        exp_first_tag = 4'hA; exp_second_tag = 4'hB;
`else
        exp_first_tag = 4'hB; exp_second_tag = 4'hA;
`endif
        step();
        check("ord_first_tag", iss_tag, exp_first_tag);
        check("ord_first_vj", iss_vj, 32'h77);
        step();
        check("ord_second_tag", iss_tag, exp_second_tag);
        check("ord_second_vj", iss_vj, 32'h77);
        step();
        check("ord_end_iss", iss_valid, 0);
        check("ord_end_count", count, 4);

        // Freeze, then flush with a dispatch and a matching broadcast in the same cycle
        rdy = 1'b0;
        set_disp(6'd19, 32'h5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd10};
        cdb_value = {32'd0, 32'd1};
        #1;
        check("frz_disp_ready", disp_ready, 0);
        step();
        check("frz_count", count, 4);
        check("frz_iss_valid", iss_valid, 0);
        rdy        = 1'b1;
        disp_valid = 1'b0;
        cdb_valid  = '0;
        step();
        step();
        check("frz_no_wake_iss", iss_valid, 0);
        check("frz_no_wake_count", count, 4);
        flush      = 1'b1;
        disp_valid = 1'b1;
        cdb_valid  = 2'b01;
        step();
        flush      = 1'b0;
        disp_valid = 1'b0;
        cdb_valid  = '0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_iss_valid", iss_valid, 0);
        check("flush_disp_ready", disp_ready, 1);
        step();
        step();
        step();
        check("flush_no_write_iss", iss_valid, 0);
        check("flush_no_write_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
